mem_access_unit: RTL and testbench
==================================

// Module: mem_access_unit
// PURPOSE
// Requester side of the byte-addressed data memory port: accepts load/store
// requests from the execute stage (valid/ready), decodes RV32 funct3 into
// width/sign_extend, and drives one memory access per request.
// Captures valM/mem_fault and returns a registered response (valid/ready).
// Sits between the execute/writeback stages and the data memory.
// PARAMETERS
// XLEN            32   data/address width (only 32 supported)
// ALLOW_MISALIGN  0    1: misaligned accesses go to memory; 0: faulted locally
// PORTS
// clock        in   1     rising-edge clock
// reset_n      in   1     async active-low reset
// req_valid    in   1     request present
// req_ready    out  1     unit can accept (high only in IDLE)
// req_store    in   1     1=store, 0=load
// req_funct3   in   3     RV32 funct3 of LOAD/STORE opcode
// req_addr     in   XLEN  byte address
// req_wdata    in   XLEN  store data (low bytes used for SB/SH)
// rsp_valid    out  1     response present
// rsp_ready    in   1     consumer takes response
// rsp_data     out  XLEN  load result (extended); 0 for stores/faults
// rsp_cause    out  2     mau_cause_e: NONE/ACCESS/MISALIGNED/ILLEGAL
// mem_addr     out  XLEN  to memory addr
// mem_wdata    out  XLEN  to memory wdata
// mem_width    out  2     00 byte, 01 half, 10 word
// mem_sext     out  1     to memory sign_extend
// mem_read_en  out  1     to memory read_en
// mem_write_en out  1     to memory write_en
// mem_valM     in   XLEN  from memory (combinational, valid same cycle)
// mem_fault    in   1     from memory (combinational, valid same cycle)
// BEHAVIOUR
// - Reset: state=IDLE; req_ready=1 after reset; rsp_valid=0, rsp_data=0,
//   rsp_cause=NONE; all mem_* outputs 0. Reset mid-ACCESS aborts: enables drop
//   asynchronously, so an in-flight store is not committed.
// - FSM IDLE -> ACCESS -> RESP -> IDLE. Accept on req_valid&&req_ready edge;
//   request fields latched into a register.
// - Decode at accept: load 000 LB(b,sext) 001 LH(h,sext) 010 LW 100 LBU 101 LHU;
//   store 000 SB 001 SH 010 SW. Any other funct3 -> cause ILLEGAL.
// - Misaligned: half with addr[0]!=0, word with addr[1:0]!=0; if ALLOW_MISALIGN=0
//   -> cause MISALIGNED. ILLEGAL has priority over MISALIGNED.
// - Local fault: IDLE -> RESP directly, no memory enable ever asserted.
// - ACCESS (exactly 1 cycle): mem_* driven from latched request (outputs are
//   registers/decoded from latched state, never from req_* directly);
//   read_en=!store, write_en=store. At the ending edge capture
//   rsp_data = (load && !mem_fault) ? mem_valM : 0; cause = mem_fault ? ACCESS : NONE.
//   Store commits in memory on the same edge.
// - Latency: accept edge N -> ACCESS in cycle N+1 -> rsp_valid from N+2
//   (from N+1 for local faults).
// - RESP: rsp_valid=1, rsp_* stable until rsp_ready; on rsp_valid&&rsp_ready
//   -> IDLE. req_ready=0 in ACCESS/RESP (no back-to-back overlap).
// - Max throughput: one request per 3 cycles.
// STRUCTURE
// - Package mau_pkg: typedef enum {IDLE,ACCESS,RESP} mau_state_e;
//   enum logic[1:0] mau_cause_e {NONE=0,ACCESS=1,MISALIGNED=2,ILLEGAL=3};
//   funct3 localparams F3_B/H/W/BU/HU; WIDTH_B/H/W.
// - Sub-module mau_decode (combinational): funct3/store/addr -> width, sext, cause.
// TESTING (bench instantiates mau + memory, MEM_SIZE=1024)
// - SW 0xDEADBEEF @0x100, then LW @0x100 -> rsp_data=0xDEADBEEF, cause NONE,
//   rsp_valid 2 cycles after accept.
// - After above: LB @0x103 -> 0xFFFFFFDE; LBU @0x103 -> 0x000000DE;
//   LH @0x102 -> 0xFFFFDEAD; LHU @0x102 -> 0x0000DEAD.
// - LW @0x102 (ALLOW_MISALIGN=0) -> cause MISALIGNED, rsp_valid next cycle,
//   read_en/write_en never high.
// - SW @0x0 and LW @0x3FE -> cause ACCESS, rsp_data=0; memory contents unchanged.
// - funct3=011 load, funct3=100 store -> cause ILLEGAL, no memory enable.
// - rsp_ready low 3 cycles -> rsp held stable, req_ready=0.
// - reset_n low in ACCESS of SW 0x12345678 @0x200 -> write_en drops at once,
//   later LW @0x200 != 0x12345678.

Source files
------------

// File: rtl/mau_pkg.sv
// mau_pkg: shared types and constants for the memory access unit
package mau_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } mau_state_e;

    typedef enum logic [1:0] {
        CAUSE_NONE       = 2'd0,
        CAUSE_ACCESS     = 2'd1,
        CAUSE_MISALIGNED = 2'd2,
        CAUSE_ILLEGAL    = 2'd3
    } mau_cause_e;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam logic [1:0] WIDTH_B = 2'b00;
    localparam logic [1:0] WIDTH_H = 2'b01;
    localparam logic [1:0] WIDTH_W = 2'b10;

endpackage

// File: rtl/mau_decode.sv
// mau_decode: RV32 load/store funct3 and address alignment to width, sign-extend and local cause
module mau_decode
    import mau_pkg::*;
#(
    parameter int ALLOW_MISALIGN = 0
) (
    input  logic       store,
    input  logic [2:0] funct3,
    input  logic [1:0] addr_lo,
    output logic [1:0] width,
    output logic       sext,
    output mau_cause_e cause
);

    logic legal;
    logic misaligned;

    always_comb begin
        width = WIDTH_B;
        sext  = 1'b0;
        legal = 1'b0;
        case (funct3)
            F3_B: begin
                width = WIDTH_B;
                sext  = !store;
                legal = 1'b1;
            end
            F3_H: begin
                width = WIDTH_H;
                sext  = !store;
                legal = 1'b1;
            end
            F3_W: begin
                width = WIDTH_W;
                legal = 1'b1;
            end
            F3_BU: begin
                width = WIDTH_B;
                legal = !store;
            end
            F3_HU: begin
                width = WIDTH_H;
                legal = !store;
            end
            default: legal = 1'b0;
        endcase
        misaligned = (width == WIDTH_H && addr_lo[0]) || (width == WIDTH_W && addr_lo != 2'b00);
        cause = !legal ? CAUSE_ILLEGAL
              : (misaligned && ALLOW_MISALIGN == 0) ? CAUSE_MISALIGNED
              : CAUSE_NONE;
    end

endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit: accepts load/store requests, performs one memory access each, returns a registered response
module mem_access_unit
    import mau_pkg::*;
#(
    parameter int XLEN           = 32,
    parameter int ALLOW_MISALIGN = 0
) (
    input  logic            clock,
    input  logic            reset_n,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic            req_store,
    input  logic [2:0]      req_funct3,
    input  logic [XLEN-1:0] req_addr,
    input  logic [XLEN-1:0] req_wdata,
    output logic            rsp_valid,
    input  logic            rsp_ready,
    output logic [XLEN-1:0] rsp_data,
    output logic [1:0]      rsp_cause,
    output logic [XLEN-1:0] mem_addr,
    output logic [XLEN-1:0] mem_wdata,
    output logic [1:0]      mem_width,
    output logic            mem_sext,
    output logic            mem_read_en,
    output logic            mem_write_en,
    input  logic [XLEN-1:0] mem_valM,
    input  logic            mem_fault
);

    mau_state_e      state_q, state_d;
    mau_cause_e      cause_q, cause_d, dec_cause;
    logic            store_q, store_d;
    logic            sext_q, sext_d, dec_sext;
    logic [1:0]      width_q, width_d, dec_width;
    logic [XLEN-1:0] addr_q, addr_d;
    logic [XLEN-1:0] wdata_q, wdata_d;
    logic [XLEN-1:0] data_q, data_d;
    logic            in_access;

    mau_decode #(.ALLOW_MISALIGN(ALLOW_MISALIGN)) u_decode (
        .store   (req_store),
        .funct3  (req_funct3),
        .addr_lo (req_addr[1:0]),
        .width   (dec_width),
        .sext    (dec_sext),
        .cause   (dec_cause)
    );

    // Locally faulted requests skip ACCESS so no memory enable is ever raised for them
    always_comb begin
        state_d = state_q;
        cause_d = cause_q;
        store_d = store_q;
        sext_d  = sext_q;
        width_d = width_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        data_d  = data_q;
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    store_d = req_store;
                    sext_d  = dec_sext;
                    width_d = dec_width;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    data_d  = '0;
                    cause_d = dec_cause;
                    state_d = (dec_cause == CAUSE_NONE) ? ST_ACCESS : ST_RESP;
                end
            end
            ST_ACCESS: begin
                data_d  = (!store_q && !mem_fault) ? mem_valM : '0;
                cause_d = mem_fault ? CAUSE_ACCESS : CAUSE_NONE;
                state_d = ST_RESP;
            end
            ST_RESP: begin
                if (rsp_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            cause_q <= CAUSE_NONE;
            store_q <= 1'b0;
            sext_q  <= 1'b0;
            width_q <= WIDTH_B;
            addr_q  <= '0;
            wdata_q <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            cause_q <= cause_d;
            store_q <= store_d;
            sext_q  <= sext_d;
            width_q <= width_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            data_q  <= data_d;
        end
    end

    // Memory port is decoded from registered state only, so reset drops it asynchronously
    assign in_access    = state_q == ST_ACCESS;
    assign req_ready    = state_q == ST_IDLE;
    assign rsp_valid    = state_q == ST_RESP;
    assign rsp_data     = data_q;
    assign rsp_cause    = cause_q;
    assign mem_addr     = in_access ? addr_q : '0;
    assign mem_wdata    = in_access ? wdata_q : '0;
    assign mem_width    = in_access ? width_q : WIDTH_B;
    assign mem_sext     = in_access && sext_q;
    assign mem_read_en  = in_access && !store_q;
    assign mem_write_en = in_access && store_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: two units (strict and misalign-tolerant) on byte memories, checked against a request-level model
module tb_mem_access_unit;
    import mau_pkg::*;

    localparam int MEM_SIZE = 1024;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    logic        req_valid [2];
    logic        req_store [2];
    logic        rsp_ready [2];
    logic [2:0]  req_funct3 [2];
    logic [31:0] req_addr [2];
    logic [31:0] req_wdata [2];
    wire         req_ready [2];
    wire         rsp_valid [2];
    wire         mem_sext [2];
    wire         mem_read_en [2];
    wire         mem_write_en [2];
    wire         mem_fault [2];
    wire  [31:0] rsp_data [2];
    wire  [31:0] mem_addr [2];
    wire  [31:0] mem_wdata [2];
    wire  [31:0] mem_valM [2];
    wire  [1:0]  rsp_cause [2];
    wire  [1:0]  mem_width [2];

    logic [7:0] mem [2][MEM_SIZE] = '{default: '0};
    logic [7:0] ref_mem [2][MEM_SIZE] = '{default: '0};

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int en_cnt [2] = '{0, 0};

    bit          m_pend [2] = '{0, 0};
    bit          m_mem [2];
    bit          m_st [2];
    bit          m_sext [2];
    int          m_acc [2];
    int          m_lat [2];
    int          m_n [2];
    logic [31:0] m_addr [2];
    logic [31:0] m_wdata [2];
    logic [31:0] m_data [2];
    logic [1:0]  m_cause [2];

    function automatic int nbytes(logic [1:0] w);
        return (w == 2'b00) ? 1 : (w == 2'b01) ? 2 : 4;
    endfunction

    // Bench memory: first 16 bytes are write-protected, nothing may run past the end
    function automatic bit mem_bad(bit wr, logic [31:0] a, int n);
        return (a + 32'(n) > 32'(MEM_SIZE)) || (wr && a < 32'd16);
    endfunction

    function automatic logic [31:0] extend(logic [31:0] r, int n, bit s);
        logic [31:0] m = (n == 4) ? 32'hFFFF_FFFF : (32'd1 << (8 * n)) - 32'd1;
        return ((s && r[8*n-1]) ? ~m : 32'h0) | (r & m);
    endfunction

    function automatic logic [31:0] ref_word(int i, logic [31:0] a);
        logic [31:0] r = '0;
        for (int k = 0; k < 4; k++) r[8*k +: 8] = ref_mem[i][10'(a + 32'(k))];
        return r;
    endfunction

    task automatic check(input string name, input int i, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s[%0d] got %h expected %h at cycle %0d", name, i, act, exp, cyc);
        end
    endtask

    for (genvar g = 0; g < 2; g++) begin : g_u
        logic [31:0] raw;
        mem_access_unit #(.XLEN(32), .ALLOW_MISALIGN(g)) dut (
            .clock        (clk),
            .reset_n      (reset_n),
            .req_valid    (req_valid[g]),
            .req_ready    (req_ready[g]),
            .req_store    (req_store[g]),
            .req_funct3   (req_funct3[g]),
            .req_addr     (req_addr[g]),
            .req_wdata    (req_wdata[g]),
            .rsp_valid    (rsp_valid[g]),
            .rsp_ready    (rsp_ready[g]),
            .rsp_data     (rsp_data[g]),
            .rsp_cause    (rsp_cause[g]),
            .mem_addr     (mem_addr[g]),
            .mem_wdata    (mem_wdata[g]),
            .mem_width    (mem_width[g]),
            .mem_sext     (mem_sext[g]),
            .mem_read_en  (mem_read_en[g]),
            .mem_write_en (mem_write_en[g]),
            .mem_valM     (mem_valM[g]),
            .mem_fault    (mem_fault[g])
        );
        always_comb begin
            raw = '0;
            for (int k = 0; k < 4; k++) raw[8*k +: 8] = mem[g][10'(mem_addr[g] + 32'(k))];
        end
        assign mem_fault[g] = (mem_read_en[g] || mem_write_en[g]) && mem_bad(mem_write_en[g], mem_addr[g], nbytes(mem_width[g]));
        assign mem_valM[g]  = mem_read_en[g] ? extend(raw, nbytes(mem_width[g]), mem_sext[g]) : 32'h0;
    end

    always @(posedge clk) begin
        for (int i = 0; i < 2; i++)
            if (mem_write_en[i] && !mem_fault[i])
                for (int k = 0; k < nbytes(mem_width[i]); k++)
                    mem[i][10'(mem_addr[i] + 32'(k))] <= mem_wdata[i][8*k +: 8];
    end

    always @(negedge clk) begin
        for (int i = 0; i < 2; i++)
            if (mem_read_en[i] || mem_write_en[i]) en_cnt[i] <= en_cnt[i] + 1;
    end

    function automatic bit legal(bit st, logic [2:0] f3);
        return st ? (f3 <= 3'd2) : (f3 <= 3'd2 || f3 == 3'd4 || f3 == 3'd5);
    endfunction

    function automatic logic [1:0] local_cause(int i, bit st, logic [2:0] f3, logic [31:0] a);
        int n = 1 << f3[1:0];
        if (!legal(st, f3)) return CAUSE_ILLEGAL;
        if (i == 0 && (a % 32'(n)) != 0) return CAUSE_MISALIGNED;
        return CAUSE_NONE;
    endfunction

    // Request-level model: a request occupies the unit from acceptance until its response is taken
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < 2; i++) m_pend[i] <= 1'b0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (m_pend[i] && m_mem[i] && cyc == m_acc[i] + 1) begin
                    m_cause[i] <= mem_bad(m_st[i], m_addr[i], m_n[i]) ? CAUSE_ACCESS : CAUSE_NONE;
                    m_data[i]  <= (m_st[i] || mem_bad(m_st[i], m_addr[i], m_n[i])) ? 32'h0
                                : extend(ref_word(i, m_addr[i]), m_n[i], m_sext[i]);
                    if (m_st[i] && !mem_bad(1'b1, m_addr[i], m_n[i]))
                        for (int k = 0; k < m_n[i]; k++)
                            ref_mem[i][10'(m_addr[i] + 32'(k))] <= m_wdata[i][8*k +: 8];
                end else if (m_pend[i] && cyc >= m_acc[i] + m_lat[i] && rsp_ready[i]) begin
                    m_pend[i] <= 1'b0;
                end else if (!m_pend[i] && req_valid[i]) begin
                    m_pend[i]  <= 1'b1;
                    m_acc[i]   <= cyc;
                    m_st[i]    <= req_store[i];
                    m_addr[i]  <= req_addr[i];
                    m_wdata[i] <= req_wdata[i];
                    m_n[i]     <= 1 << req_funct3[i][1:0];
                    m_sext[i]  <= !req_store[i] && (req_funct3[i] == 3'd0 || req_funct3[i] == 3'd1);
                    m_data[i]  <= 32'h0;
                    m_cause[i] <= local_cause(i, req_store[i], req_funct3[i], req_addr[i]);
                    m_mem[i]   <= local_cause(i, req_store[i], req_funct3[i], req_addr[i]) == CAUSE_NONE;
                    m_lat[i]   <= (local_cause(i, req_store[i], req_funct3[i], req_addr[i]) == CAUSE_NONE) ? 2 : 1;
                end
            end
            cyc <= cyc + 1;
        end
    end

    always @(negedge clk) begin
        if (reset_n) begin
            for (int i = 0; i < 2; i++) begin
                automatic bit ev = m_pend[i] && cyc >= m_acc[i] + m_lat[i];
                automatic bit ea = m_pend[i] && m_mem[i] && cyc == m_acc[i] + 1;
                check("req_ready", i, req_ready[i], !m_pend[i]);
                check("rsp_valid", i, rsp_valid[i], ev);
                check("read_en", i, mem_read_en[i], ea && !m_st[i]);
                check("write_en", i, mem_write_en[i], ea && m_st[i]);
                if (ev) begin
                    check("m_rsp_data", i, rsp_data[i], m_data[i]);
                    check("m_rsp_cause", i, rsp_cause[i], m_cause[i]);
                end
                if (ea) begin
                    check("mem_addr", i, mem_addr[i], m_addr[i]);
                    check("mem_wdata", i, mem_wdata[i], m_wdata[i]);
                    check("mem_width", i, mem_width[i], (m_n[i] == 1) ? 0 : (m_n[i] == 2) ? 1 : 2);
                    check("mem_sext", i, mem_sext[i], m_sext[i]);
                end
            end
        end
    end

    task automatic do_req(input int i, input bit st, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] wd, input int hold, input logic [31:0] ed,
                          input logic [1:0] ec, input int el);
        int n = 0;
        int e0 = en_cnt[i];
        req_valid[i] = 1'b1;
        req_store[i] = st;
        req_funct3[i] = f3;
        req_addr[i] = a;
        req_wdata[i] = wd;
        while (!req_ready[i] && n < 20) begin
            @(negedge clk);
            #1 n++;
        end
        check("accept_wait", i, n, 0);
        @(posedge clk);
        #1 req_valid[i] = 1'b0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!rsp_valid[i] && n < 20);
        check("latency", i, n, el);
        for (int h = 0; h <= hold; h++) begin
            if (h > 0) @(negedge clk);
            check("rsp_data", i, rsp_data[i], ed);
            check("rsp_cause", i, rsp_cause[i], ec);
            check("busy_ready", i, req_ready[i], 0);
        end
        #1 rsp_ready[i] = 1'b1;
        @(posedge clk);
        #1 rsp_ready[i] = 1'b0;
        if (ec == CAUSE_MISALIGNED || ec == CAUSE_ILLEGAL) check("no_mem_en", i, en_cnt[i] - e0, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 2; i++) begin
            req_valid[i] = 1'b0;
            req_store[i] = 1'b0;
            req_funct3[i] = 3'd0;
            req_addr[i] = 32'h0;
            req_wdata[i] = 32'h0;
            rsp_ready[i] = 1'b0;
        end
        repeat (2) @(negedge clk);
        check("rst_req_ready", 0, req_ready[0], 1);
        check("rst_rsp_valid", 0, rsp_valid[0], 0);
        check("rst_rsp_data", 0, rsp_data[0], 0);
        check("rst_rsp_cause", 0, rsp_cause[0], CAUSE_NONE);
        check("rst_read_en", 0, mem_read_en[0], 0);
        check("rst_write_en", 0, mem_write_en[0], 0);
        check("rst_mem_addr", 0, mem_addr[0], 0);
        check("rst_mem_wdata", 0, mem_wdata[0], 0);
        check("rst_mem_width", 0, mem_width[0], 0);
        check("rst_mem_sext", 0, mem_sext[0], 0);
        #1 reset_n = 1'b1;

        do_req(0, 1'b1, F3_W,  32'h100, 32'hDEADBEEF, 0, 32'h0,        CAUSE_NONE,       2);
        do_req(0, 1'b0, F3_W,  32'h100, 32'h0,        0, 32'hDEADBEEF, CAUSE_NONE,       2);
        do_req(0, 1'b0, F3_B,  32'h103, 32'h0,        0, 32'hFFFFFFDE, CAUSE_NONE,       2);
        do_req(0, 1'b0, F3_BU, 32'h103, 32'h0,        0, 32'h000000DE, CAUSE_NONE,       2);
        do_req(0, 1'b0, F3_H,  32'h102, 32'h0,        0, 32'hFFFFDEAD, CAUSE_NONE,       2);
        do_req(0, 1'b0, F3_HU, 32'h102, 32'h0,        0, 32'h0000DEAD, CAUSE_NONE,       2);
        do_req(0, 1'b1, F3_B,  32'h108, 32'h000000A5, 0, 32'h0,        CAUSE_NONE,       2);
        do_req(0, 1'b1, F3_H,  32'h10A, 32'h0000C37E, 0, 32'h0,        CAUSE_NONE,       2);
        do_req(0, 1'b0, F3_W,  32'h108, 32'h0,        0, 32'hC37E00A5, CAUSE_NONE,       2);
        do_req(0, 1'b0, F3_W,  32'h102, 32'h0,        0, 32'h0,        CAUSE_MISALIGNED, 1);
        do_req(0, 1'b0, F3_H,  32'h101, 32'h0,        0, 32'h0,        CAUSE_MISALIGNED, 1);
        do_req(0, 1'b1, F3_W,  32'h0,   32'hCAFEF00D, 0, 32'h0,        CAUSE_ACCESS,     2);
        do_req(0, 1'b0, F3_W,  32'h0,   32'h0,        0, 32'h0,        CAUSE_NONE,       2);
        do_req(0, 1'b0, 3'b011, 32'h100, 32'h0,       0, 32'h0,        CAUSE_ILLEGAL,    1);
        do_req(0, 1'b1, 3'b100, 32'h100, 32'h1,       0, 32'h0,        CAUSE_ILLEGAL,    1);
        do_req(0, 1'b1, 3'b011, 32'h101, 32'h1,       0, 32'h0,        CAUSE_ILLEGAL,    1);
        do_req(0, 1'b0, F3_W,  32'h100, 32'h0,        3, 32'hDEADBEEF, CAUSE_NONE,       2);

        do_req(1, 1'b1, F3_W,  32'h100, 32'hDEADBEEF, 0, 32'h0,        CAUSE_NONE,       2);
        do_req(1, 1'b1, F3_W,  32'h104, 32'h11223344, 0, 32'h0,        CAUSE_NONE,       2);
        do_req(1, 1'b0, F3_W,  32'h102, 32'h0,        0, 32'h3344DEAD, CAUSE_NONE,       2);
        do_req(1, 1'b0, F3_H,  32'h101, 32'h0,        0, 32'hFFFFADBE, CAUSE_NONE,       2);
        do_req(1, 1'b0, F3_W,  32'h3FE, 32'h0,        0, 32'h0,        CAUSE_ACCESS,     2);
        do_req(1, 1'b0, 3'b110, 32'h100, 32'h0,       0, 32'h0,        CAUSE_ILLEGAL,    1);

        req_valid[0] = 1'b1;
        req_store[0] = 1'b1;
        req_funct3[0] = F3_W;
        req_addr[0] = 32'h200;
        req_wdata[0] = 32'h12345678;
        @(posedge clk);
        #1 req_valid[0] = 1'b0;
        @(negedge clk);
        check("abort_we_before", 0, mem_write_en[0], 1);
        #2 reset_n = 1'b0;
        #1 check("abort_we_after", 0, mem_write_en[0], 0);
        check("abort_ready", 0, req_ready[0], 1);
        @(negedge clk);
        #1 reset_n = 1'b1;
        do_req(0, 1'b0, F3_W, 32'h200, 32'h0, 0, 32'h0, CAUSE_NONE, 2);
        check("abort_not_committed", 0, rsp_data[0] == 32'h12345678, 0);

        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
